image_sample_fetch: RTL and testbench

Sequencer that sits directly downstream of the image-sample ROM and upstream of the FFT input buffer. On a start pulse it walks N_POINTS consecutive ROM addresses from BASE_ADDR and absorbs the ROM's one-cycle registered read latency. It streams each IEEE-754 single-precision word out as a complex sample (real = ROM word, imaginary = 0) on a valid/ready interface with full backpressure support. Each frame ends with a last-sample marker and a done pulse.

---
 rtl/image_sample_fetch.sv | 167 ++++++++++++++++
 tb/tb_image_sample_fetch.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/image_sample_fetch.sv
// Sequencer between the image-sample ROM and the FFT input buffer: walks N_POINTS
// ROM addresses, hides the ROM's one-cycle read latency, streams complex samples.
module image_sample_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int N_POINTS   = 8,
    parameter int BASE_ADDR  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_wr_ena,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] out_re,
    output logic [DATA_WIDTH-1:0] out_im,
    output logic [ADDR_WIDTH-1:0] out_idx,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LP_N    = ADDR_WIDTH'(N_POINTS);
    localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(N_POINTS - 1);
    localparam logic [ADDR_WIDTH-1:0] LP_BASE = ADDR_WIDTH'(BASE_ADDR);

    state_t                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic [ADDR_WIDTH-1:0] r_rom_addr;
    logic [ADDR_WIDTH-1:0] r_issue_cnt;
    logic                  r_inflight;
    logic [ADDR_WIDTH-1:0] r_inflight_idx;

    logic [DATA_WIDTH-1:0] r_fifo_data [3];
    logic [ADDR_WIDTH-1:0] r_fifo_idx  [3];
    logic [1:0]            r_wr_ptr;
    logic [1:0]            r_rd_ptr;
    logic [1:0]            r_fifo_cnt;

    logic                  w_valid;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_issue;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic [ADDR_WIDTH-1:0] w_head_idx;
    logic [1:0]            w_wr_ptr_nxt;
    logic [1:0]            w_rd_ptr_nxt;

    // A read in flight holds a FIFO credit, so three credits bound FIFO occupancy.
    assign w_valid = (r_fifo_cnt != 2'd0);
    assign w_pop   = w_valid & out_ready;
    assign w_push  = r_inflight;
    assign w_issue = (r_state == S_FETCH) && (r_issue_cnt < LP_N)
                     && (({1'b0, r_fifo_cnt} + {2'b00, r_inflight}) < 3'd3);

    assign w_wr_ptr_nxt = (r_wr_ptr == 2'd2) ? 2'd0 : r_wr_ptr + 2'd1;
    assign w_rd_ptr_nxt = (r_rd_ptr == 2'd2) ? 2'd0 : r_rd_ptr + 2'd1;

    always_comb begin
        w_head_data = r_fifo_data[0];
        w_head_idx  = r_fifo_idx[0];
        case (r_rd_ptr)
            2'd1: begin
                w_head_data = r_fifo_data[1];
                w_head_idx  = r_fifo_idx[1];
            end
            2'd2: begin
                w_head_data = r_fifo_data[2];
                w_head_idx  = r_fifo_idx[2];
            end
            default: ;
        endcase
    end

    assign w_last = w_valid && (w_head_idx == LP_LAST);

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 3; i++) begin
            if (w_push && (r_wr_ptr == 2'(i))) begin
                r_fifo_data[i] <= rom_data;
                r_fifo_idx[i]  <= r_inflight_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_rom_addr     <= LP_BASE;
            r_issue_cnt    <= '0;
            r_inflight     <= 1'b0;
            r_inflight_idx <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_fifo_cnt     <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_rom_addr     <= r_rom_addr + 1'b1;
                r_issue_cnt    <= r_issue_cnt + 1'b1;
                r_inflight_idx <= r_issue_cnt;
            end

            if (w_push) r_wr_ptr <= w_wr_ptr_nxt;
            if (w_pop)  r_rd_ptr <= w_rd_ptr_nxt;
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
                default: ;
            endcase

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_FETCH;
                        r_busy      <= 1'b1;
                        r_issue_cnt <= '0;
                        r_rom_addr  <= LP_BASE;
                        r_inflight  <= 1'b0;
                        r_wr_ptr    <= '0;
                        r_rd_ptr    <= '0;
                        r_fifo_cnt  <= '0;
                    end
                end
                S_FETCH: begin
                    if (w_issue && (r_issue_cnt == LP_LAST)) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_pop && w_last) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign rom_addr   = r_rom_addr;
    assign rom_wr_ena = 1'b0;
    assign out_valid  = w_valid;
    assign out_re     = w_valid ? w_head_data : '0;
    assign out_im     = '0;
    assign out_idx    = w_valid ? w_head_idx : '0;
    assign out_last   = w_last;

endmodule

// File: tb/tb_image_sample_fetch.sv
// Directed bench for image_sample_fetch: default frame, backpressure, random ready,
// mid-frame reset, ignored starts, and a single-sample configuration.
module tb_image_sample_fetch;

    localparam logic [31:0] EXP [8] = '{32'h3F800011, 32'h3F000012, 32'h40000013, 32'h3E800014,
                                        32'h3E000015, 32'h3F800016, 32'h3F000017, 32'h40000018};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    // DUT A: default parameters
    logic        start_a = 1'b0, out_ready_a = 1'b0;
    logic        busy_a, done_a, rom_wr_ena_a, out_last_a, out_valid_a;
    logic [11:0] rom_addr_a, out_idx_a;
    logic [31:0] rom_q_a, out_re_a, out_im_a;

    // DUT B: single sample at address 8
    logic        start_b = 1'b0, out_ready_b = 1'b0;
    logic        busy_b, done_b, rom_wr_ena_b, out_last_b, out_valid_b;
    logic [11:0] rom_addr_b, out_idx_b;
    logic [31:0] rom_q_b, out_re_b, out_im_b;

    image_sample_fetch dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
        .rom_addr(rom_addr_a), .rom_wr_ena(rom_wr_ena_a), .rom_data(rom_q_a),
        .out_re(out_re_a), .out_im(out_im_a), .out_idx(out_idx_a), .out_last(out_last_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a)
    );

    image_sample_fetch #(.N_POINTS(1), .BASE_ADDR(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
        .rom_addr(rom_addr_b), .rom_wr_ena(rom_wr_ena_b), .rom_data(rom_q_b),
        .out_re(out_re_b), .out_im(out_im_b), .out_idx(out_idx_b), .out_last(out_last_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b)
    );

    function automatic logic [31:0] rom_word(input logic [11:0] a);
        case (a)
            12'd1:   return 32'h3F800011;
            12'd2:   return 32'h3F000012;
            12'd3:   return 32'h40000013;
            12'd4:   return 32'h3E800014;
            12'd5:   return 32'h3E000015;
            12'd6:   return 32'h3F800016;
            12'd7:   return 32'h3F000017;
            12'd8:   return 32'h40000018;
            default: return {20'hBAD00, a};
        endcase
    endfunction

    // Registered-read ROM models
    always @(posedge clk) begin
        rom_q_a <= rom_word(rom_addr_a);
        rom_q_b <= rom_word(rom_addr_b);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
    endtask

    // Consumes one frame from DUT A; ready is 1 or a 50% random pattern.
    task automatic collect_frame(input bit rnd, input string tag);
        int   k = 0;
        int   dones = 0;
        logic prev_stall = 1'b0;
        for (int c = 0; c < 300 && dones == 0; c++) begin
            out_ready_a = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_stall) check({tag, "_stall_valid"}, 64'(out_valid_a), 64'd1);
            if (done_a) dones++;
            if (out_valid_a) begin
                check({tag, "_re"}, 64'(out_re_a), 64'((k < 8) ? EXP[k] : 32'hFFFFFFFF));
                check({tag, "_idx"}, 64'(out_idx_a), 64'(k));
                check({tag, "_last"}, 64'(out_last_a), 64'(k == 7));
                check({tag, "_im"}, 64'(out_im_a), 64'd0);
                if (out_ready_a) k++;
            end
            prev_stall = out_valid_a && !out_ready_a;
            step();
        end
        check({tag, "_count"}, 64'(k), 64'd8);
        check({tag, "_dones"}, 64'(dones), 64'd1);
        check({tag, "_done_pulse"}, 64'(done_a), 64'd0);
        check({tag, "_busy_end"}, 64'(busy_a), 64'd0);
        out_ready_a = 1'b1;
    endtask

    initial begin
        int hs;
        int dn;

        // Reset values
        step();
        step();
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_done", 64'(done_a), 64'd0);
        check("rst_valid", 64'(out_valid_a), 64'd0);
        check("rst_last", 64'(out_last_a), 64'd0);
        check("rst_re", 64'(out_re_a), 64'd0);
        check("rst_im", 64'(out_im_a), 64'd0);
        check("rst_idx", 64'(out_idx_a), 64'd0);
        check("rst_addr_a", 64'(rom_addr_a), 64'd1);
        check("rst_wr_ena", 64'(rom_wr_ena_a), 64'd0);
        check("rst_addr_b", 64'(rom_addr_b), 64'd8);
        rst_n = 1'b1;
        step();
        step();

        // Full-rate frame, explicit cycle timing
        out_ready_a = 1'b1;
        pulse_start_a();
        check("f1_busy_e0", 64'(busy_a), 64'd1);
        check("f1_valid_e0", 64'(out_valid_a), 64'd0);
        step();
        check("f1_valid_e1", 64'(out_valid_a), 64'd0);
        check("f1_addr_e1", 64'(rom_addr_a), 64'd2);
        step();
        for (int i = 0; i < 8; i++) begin
            check("f1_valid", 64'(out_valid_a), 64'd1);
            check("f1_re", 64'(out_re_a), 64'(EXP[i]));
            check("f1_idx", 64'(out_idx_a), 64'(i));
            check("f1_im", 64'(out_im_a), 64'd0);
            check("f1_last", 64'(out_last_a), 64'(i == 7));
            check("f1_nodone", 64'(done_a), 64'd0);
            step();
        end
        check("f1_done", 64'(done_a), 64'd1);
        check("f1_busy_fall", 64'(busy_a), 64'd0);
        check("f1_valid_end", 64'(out_valid_a), 64'd0);
        step();
        check("f1_done_once", 64'(done_a), 64'd0);

        // Backpressure right after the first sample
        out_ready_a = 1'b0;
        pulse_start_a();
        step();
        step();
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 64'(out_valid_a), 64'd1);
            check("bp_re", 64'(out_re_a), 64'h3F800011);
            check("bp_idx", 64'(out_idx_a), 64'd0);
            step();
        end
        check("bp_addr_stop", 64'(rom_addr_a), 64'd4);
        collect_frame(1'b0, "bp");

        // Random ready over 20 frames
        for (int f = 0; f < 20; f++) begin
            pulse_start_a();
            collect_frame(1'b1, "rnd");
        end

        // Reset mid-frame at idx 3, then restart
        out_ready_a = 1'b1;
        pulse_start_a();
        step();
        step();
        step();
        step();
        step();
        check("mr_idx3", 64'(out_idx_a), 64'd3);
        rst_n = 1'b0;
        #1;
        check("mr_valid", 64'(out_valid_a), 64'd0);
        check("mr_re", 64'(out_re_a), 64'd0);
        check("mr_idx", 64'(out_idx_a), 64'd0);
        check("mr_last", 64'(out_last_a), 64'd0);
        check("mr_busy", 64'(busy_a), 64'd0);
        check("mr_addr", 64'(rom_addr_a), 64'd1);
        step();
        check("mr_hold_valid", 64'(out_valid_a), 64'd0);
        rst_n = 1'b1;
        step();
        step();
        pulse_start_a();
        collect_frame(1'b0, "mr_restart");

        // Starts during busy and during DONE are ignored
        out_ready_a = 1'b1;
        pulse_start_a();
        hs = 0;
        dn = 0;
        for (int c = 0; c < 30; c++) begin
            start_a = (c == 3) || done_a;
            if (out_valid_a && out_ready_a) hs++;
            if (done_a) dn++;
            step();
        end
        start_a = 1'b0;
        check("ign_handshakes", 64'(hs), 64'd8);
        check("ign_dones", 64'(dn), 64'd1);
        check("ign_busy", 64'(busy_a), 64'd0);

        // Single-sample frame at BASE_ADDR=8
        out_ready_b = 1'b1;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        check("n1_busy", 64'(busy_b), 64'd1);
        step();
        check("n1_valid_e1", 64'(out_valid_b), 64'd0);
        step();
        check("n1_valid", 64'(out_valid_b), 64'd1);
        check("n1_re", 64'(out_re_b), 64'h40000018);
        check("n1_im", 64'(out_im_b), 64'd0);
        check("n1_idx", 64'(out_idx_b), 64'd0);
        check("n1_last", 64'(out_last_b), 64'd1);
        check("n1_wr_ena", 64'(rom_wr_ena_b), 64'd0);
        step();
        check("n1_done", 64'(done_b), 64'd1);
        check("n1_valid_end", 64'(out_valid_b), 64'd0);
        step();
        check("n1_done_once", 64'(done_b), 64'd0);
        check("n1_addr", 64'(rom_addr_b), 64'd9);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
